// File: rtl/io_debounce_arb_pkg.sv
// Shared types and helpers for the debounced input event arbiter.
package io_debounce_arb_pkg;

   typedef enum logic [0:0] {
      STABLE = 1'b0,
      CHECK  = 1'b1
   } deb_state_e;

   // Width of a counter that must hold values 0..n.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/io_debounce_arb_if.sv
// Event port: one edge event per handshake, producer drives valid/chan/rise.
interface io_debounce_arb_if #(
   parameter int WIDTH = 4
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic          evt_valid;
   logic          evt_ready;
   logic [CW-1:0] evt_chan;
   logic          evt_rise;

   modport master (output evt_valid, evt_chan, evt_rise, input evt_ready);
   modport slave  (input evt_valid, evt_chan, evt_rise, output evt_ready);
endinterface

// File: rtl/io_debounce_arb_synchro.sv
// Two-flop synchroniser bank for asynchronous board inputs.
module synchro #(
   parameter int width = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [width-1:0] d,
   output logic [width-1:0] q
);
   logic [width-1:0] meta;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/io_debounce_arb.sv
// Debounces WIDTH board inputs on a prescaled tick and serialises their edges
// onto a single valid/ready event port with round-robin arbitration.
module io_debounce_arb
   import io_debounce_arb_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int PRESCALE  = 1000,
   parameter int DEB_TICKS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] level_out,
   output logic [WIDTH-1:0] overrun,
   input  logic             clear_overrun,
   io_debounce_arb_if.master evt
);
   localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int CNW = cnt_width(DEB_TICKS);

   logic [WIDTH-1:0] sync, flip, pending, edge_r, consume;
   logic [PW-1:0]    pre;
   logic             tick;
   logic             valid, rise, load, found;
   logic [CW-1:0]    chan, win, rr;

   synchro #(.width(WIDTH)) u_sync (
      .clk    (clk),
      .resetn (~reset),
      .d      (data_in),
      .q      (sync)
   );

   assign tick = (pre == PW'(PRESCALE - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     pre <= '0;
      else if (tick) pre <= '0;
      else           pre <= pre + 1'b1;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      deb_state_e     state;
      logic [CNW-1:0] cnt;
      logic           lvl, pend, edg, ovr;

      // Flip on the DEB_TICKS-th consecutive tick spent disagreeing with lvl.
      assign flip[i] = (state == CHECK) && (sync[i] != lvl) && tick &&
                       (cnt == CNW'(DEB_TICKS - 1));
      assign level_out[i] = lvl;
      assign pending[i]   = pend;
      assign edge_r[i]    = edg;
      assign overrun[i]   = ovr;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state <= STABLE;
            cnt   <= '0;
            lvl   <= 1'b0;
            pend  <= 1'b0;
            edg   <= 1'b0;
            ovr   <= 1'b0;
         end else begin
            case (state)
               STABLE: if (sync[i] != lvl) begin
                  state <= CHECK;
                  cnt   <= '0;
               end
               CHECK: begin
                  if (sync[i] == lvl) state <= STABLE;
                  else if (tick) begin
                     if (flip[i]) begin
                        lvl   <= ~lvl;
                        state <= STABLE;
                     end else cnt <= cnt + 1'b1;
                  end
               end
               default: state <= STABLE;
            endcase

            // A flip racing a load of the same channel stays pending; the load takes the old edge.
            if (flip[i]) begin
               pend <= 1'b1;
               edg  <= ~lvl;
            end else if (consume[i]) pend <= 1'b0;

            if (flip[i] && pend && !consume[i]) ovr <= 1'b1;
            else if (clear_overrun)             ovr <= 1'b0;
         end
      end
   end

   assign load = !valid || evt.evt_ready;

   // First pending channel at or after rr; descending scan lets the nearest win.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = WIDTH - 1; k >= 0; k--) begin
         if (pending[(int'(rr) + k) % WIDTH]) begin
            found = 1'b1;
            win   = CW'((int'(rr) + k) % WIDTH);
         end
      end
   end

   assign consume = (load && found) ? (WIDTH'(1) << win) : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         chan  <= '0;
         rise  <= 1'b0;
         rr    <= '0;
      end else if (load) begin
         if (found) begin
            valid <= 1'b1;
            chan  <= win;
            rise  <= edge_r[win];
            rr    <= (win == CW'(WIDTH - 1)) ? '0 : win + 1'b1;
         end else valid <= 1'b0;
      end
   end

   assign evt.evt_valid = valid;
   assign evt.evt_chan  = chan;
   assign evt.evt_rise  = rise;
endmodule

// File: tb/tb_io_debounce_arb.sv
// Directed scenarios plus randomized input sequences for io_debounce_arb.
module tb_io_debounce_arb;
  localparam int W = 4, P = 4, D = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data_in, level_out, overrun;
  logic       clear_overrun;

  io_debounce_arb_if #(.WIDTH(W)) evt_if ();

  io_debounce_arb #(.WIDTH(W), .PRESCALE(P), .DEB_TICKS(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .level_out     (level_out),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .evt           (evt_if)
  );

  always #5 clk = ~clk;

  typedef struct {int chan; logic rise; int cyc;} ev_t;
  ev_t obs_q[$];
  int  cyc_n = 0;
  int  errors = 0, checks = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Record every handshake that the coming rising edge will complete.
  always @(negedge clk)
    if (reset === 1'b0 && evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1)
      obs_q.push_back('{int'(evt_if.evt_chan), evt_if.evt_rise, cyc_n});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rcyc(input int n);
    repeat (n) begin evt_if.evt_ready = 1'($urandom_range(1, 0)); cyc(1); end
  endtask

  task automatic do_reset(input logic [3:0] d);
    reset = 1'b1; data_in = d; cyc(3);
    obs_q.delete(); reset = 1'b0;
  endtask

  task automatic expect_ev(input string tag, input int chan, input logic rise);
    ev_t e;
    chk({tag, "_present"}, 32'(obs_q.size() > 0), 1);
    if (obs_q.size() > 0) begin
      e = obs_q.pop_front();
      chk({tag, "_chan"}, e.chan, chan);
      chk({tag, "_rise"}, 32'(e.rise), 32'(rise));
    end
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int n = 0;
    while (evt_if.evt_valid !== 1'b1 && n < bound) begin cyc(1); n++; end
    chk(tag, 32'(evt_if.evt_valid), 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_level"}, level_out, 0);
    chk({tag, "_valid"}, 32'(evt_if.evt_valid), 0);
    chk({tag, "_chan"},  32'(evt_if.evt_chan), 0);
    chk({tag, "_rise"},  32'(evt_if.evt_rise), 0);
    chk({tag, "_ovr"},   overrun, 0);
  endtask

  initial begin
    int         n, c0, c1;
    logic [3:0] cur, nd, exp_mask;
    ev_t        e;

    reset = 1'b1; data_in = 4'hF; clear_overrun = 1'b0; evt_if.evt_ready = 1'b1;
    cyc(3);
    chk_zero("rst");
    reset = 1'b0;
    n = 0;
    while (level_out !== 4'hF && n < 20) begin cyc(1); n++; end
    chk("rst_level", level_out, 4'hF);
    chk("rst_latency_le14", 32'(n <= 14), 1);
    cyc(8);
    for (int i = 0; i < 4; i++) expect_ev("rst_ev", i, 1'b1);
    chk("rst_extra_ev", obs_q.size(), 0);

    // Backpressure: two simultaneous rises with the consumer stalled.
    do_reset(4'h0); cyc(4);
    chk("bp_start_level", level_out, 0);
    evt_if.evt_ready = 1'b0; data_in = 4'b0101;
    wait_valid("bp_valid", 30);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("bp_hold_valid", 32'(evt_if.evt_valid), 1);
      chk("bp_hold_chan", 32'(evt_if.evt_chan), 0);
      chk("bp_hold_rise", 32'(evt_if.evt_rise), 1);
    end
    evt_if.evt_ready = 1'b1; cyc(4);
    chk("bp_two_ev", 32'(obs_q.size() >= 2), 1);
    if (obs_q.size() >= 2) begin
      c0 = obs_q[0].cyc; c1 = obs_q[1].cyc;
      chk("bp_consecutive", c1 - c0, 1);
    end
    expect_ev("bp_a", 0, 1'b1);
    expect_ev("bp_b", 2, 1'b1);

    // Round-robin: serve channel 0 alone, then 0 and 3 together.
    data_in = 4'b0100; cyc(24);
    expect_ev("rr_pre", 0, 1'b0);
    data_in = 4'b1101; cyc(24);
    expect_ev("rr_first", 3, 1'b1);
    expect_ev("rr_second", 0, 1'b1);

    // Glitch on channel 1 shorter than the debounce window.
    data_in = 4'b1111; cyc(6);
    data_in = 4'b1101; cyc(20);
    chk("glitch_level", level_out, 4'b1101);
    chk("glitch_no_ev", obs_q.size(), 0);
    data_in = 4'b1111; cyc(24);
    chk("glitch_hold_level", level_out, 4'hF);
    expect_ev("glitch_hold", 1, 1'b1);
    chk("glitch_single", obs_q.size(), 0);

    // Overrun: slot held by channel 0 while channel 2 goes up then down.
    data_in = 4'b1010; cyc(24);
    expect_ev("ovr_prep_a", 2, 1'b0);
    expect_ev("ovr_prep_b", 0, 1'b0);
    evt_if.evt_ready = 1'b0;
    data_in = 4'b1011; cyc(24);
    data_in = 4'b1111; cyc(24);
    chk("ovr_none_yet", overrun, 0);
    data_in = 4'b1011; cyc(24);
    chk("ovr_set", overrun, 4'b0100);
    chk("ovr_slot_chan", 32'(evt_if.evt_chan), 0);
    evt_if.evt_ready = 1'b1; cyc(4);
    expect_ev("ovr_ev_a", 0, 1'b1);
    expect_ev("ovr_ev_b", 2, 1'b0);
    chk("ovr_sticky", overrun, 4'b0100);
    clear_overrun = 1'b1; cyc(1); clear_overrun = 1'b0;
    chk("ovr_clear", overrun, 0);

    // Clear held across a new overrun: the set wins that cycle, then clears.
    evt_if.evt_ready = 1'b0;
    data_in = 4'b1010; cyc(24);
    data_in = 4'b1110; cyc(24);
    clear_overrun = 1'b1; data_in = 4'b1010;
    n = 0;
    while (level_out[2] !== 1'b0 && n < 30) begin cyc(1); n++; end
    chk("sc_flip_seen", 32'(level_out[2]), 0);
    chk("sc_set_wins", overrun, 4'b0100);
    cyc(1);
    chk("sc_clear_alone", overrun, 0);
    clear_overrun = 1'b0;
    evt_if.evt_ready = 1'b1; cyc(4);
    expect_ev("sc_ev_a", 0, 1'b0);
    expect_ev("sc_ev_b", 2, 1'b0);

    // Reset with an event presented and another channel mid-debounce.
    evt_if.evt_ready = 1'b0;
    data_in = 4'b1000; cyc(24);
    chk("mid_valid", 32'(evt_if.evt_valid), 1);
    data_in = 4'b0000; cyc(4);
    reset = 1'b1; #2;
    chk_zero("mid_rst");
    cyc(3);
    obs_q.delete(); reset = 1'b0; evt_if.evt_ready = 1'b1;
    cyc(30);
    chk("mid_no_stale", obs_q.size(), 0);
    chk("mid_valid_after", 32'(evt_if.evt_valid), 0);
    chk("mid_level_after", level_out, 0);

    // Random: each changed input yields exactly one edge; glitches yield none.
    cur = 4'h0;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(1, 0) == 1) begin
        data_in = cur ^ 4'(1 << $urandom_range(3, 0));
        rcyc($urandom_range(5, 1));
        data_in = cur; rcyc(3);
      end
      nd = 4'($urandom_range(15, 0));
      exp_mask = nd ^ cur;
      data_in = nd; rcyc(28);
      evt_if.evt_ready = 1'b1; cyc(8);
      chk("rnd_level", level_out, nd);
      chk("rnd_count", obs_q.size(), $countones(exp_mask));
      while (obs_q.size() > 0) begin
        e = obs_q.pop_front();
        chk("rnd_chan_expected", 32'(exp_mask[e.chan]), 1);
        chk("rnd_rise", 32'(e.rise), 32'(nd[e.chan]));
        exp_mask[e.chan] = 1'b0;
      end
      cur = nd;
    end
    chk("rnd_no_overrun", overrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
